// File: rtl/nbit_register.sv
// N-bit D-type register with asynchronous active-low reset to RST_VAL.
// No enable, no output logic: q comes straight from the flops.
module nbit_register #(
    parameter int unsigned  N       = 4,
    parameter logic [N-1:0] RST_VAL = '0
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    logic [N-1:0] q_d;
    logic [N-1:0] q_q;

    always_comb begin
        q_d = d;
    end

    // An edge that arrives while RST is still low loads RST_VAL, so a release
    // coincident with a clock edge does not capture d on that edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: tb/tb_nbit_register.sv
// Directed self-checking bench for nbit_register at widths 4, 1 and 32,
// plus a 4-bit instance with a non-zero reset value.
module tb_nbit_register;

    logic        CLK;
    logic        RST;
    logic [3:0]  d4;
    logic [3:0]  q4;
    logic [3:0]  qrv;
    logic [0:0]  d1;
    logic [0:0]  q1;
    logic [31:0] d32;
    logic [31:0] q32;

    int checks;
    int failures;

    nbit_register #(.N(4)) u_dut4 (
        .CLK (CLK),
        .RST (RST),
        .d   (d4),
        .q   (q4)
    );

    nbit_register #(.N(4), .RST_VAL(4'b0101)) u_dut_rv (
        .CLK (CLK),
        .RST (RST),
        .d   (d4),
        .q   (qrv)
    );

    nbit_register #(.N(1)) u_dut1 (
        .CLK (CLK),
        .RST (RST),
        .d   (d1),
        .q   (q1)
    );

    nbit_register #(.N(32)) u_dut32 (
        .CLK (CLK),
        .RST (RST),
        .d   (d32),
        .q   (q32)
    );

    // Period 10 ns, first rising edge at 5 ns.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset();
        RST = 1'b1;
        d4  = 4'b0000;
        d1  = 1'b0;
        d32 = 32'h0;
        #1;
        RST = 1'b0;
        #1;
        // Before any clock edge: reset must already have acted.
        checks++;
        if (q4 !== 4'b0000) begin
            failures++;
            $display("FAIL reset_async_q4: got %b expected %b", q4, 4'b0000);
        end
        checks++;
        if (qrv !== 4'b0101) begin
            failures++;
            $display("FAIL reset_async_rstval: got %b expected %b", qrv, 4'b0101);
        end
        @(posedge CLK);
        #1;
        checks++;
        if (q4 !== 4'b0000) begin
            failures++;
            $display("FAIL reset_edge_q4: got %b expected %b", q4, 4'b0000);
        end
        checks++;
        if (q1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_edge_q1: got %b expected %b", q1, 1'b0);
        end
        checks++;
        if (q32 !== 32'h0) begin
            failures++;
            $display("FAIL reset_edge_q32: got %h expected %h", q32, 32'h0);
        end
    endtask

    task automatic test_capture();
        logic [3:0] vec [4];
        logic [3:0] prev;
        vec[0] = 4'b1011;
        vec[1] = 4'b0110;
        vec[2] = 4'b1111;
        vec[3] = 4'b0001;
        prev = 4'b0000;
        @(negedge CLK);
        RST = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            d4 = vec[i];
            #1;
            checks++;
            if (q4 !== prev) begin
                failures++;
                $display("FAIL capture_pre[%0d]: got %b expected %b", i, q4, prev);
            end
            @(posedge CLK);
            #1;
            checks++;
            if (q4 !== vec[i]) begin
                failures++;
                $display("FAIL capture[%0d]: got %b expected %b", i, q4, vec[i]);
            end
            prev = vec[i];
        end
    endtask

    task automatic test_mid_reset();
        @(posedge CLK);
        #2;
        RST = 1'b0;
        #1;
        checks++;
        if (q4 !== 4'b0000) begin
            failures++;
            $display("FAIL mid_reset_q4: got %b expected %b", q4, 4'b0000);
        end
        checks++;
        if (qrv !== 4'b0101) begin
            failures++;
            $display("FAIL mid_reset_rstval: got %b expected %b", qrv, 4'b0101);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            d4 = (i % 2 == 0) ? 4'b1111 : 4'b1001;
            @(posedge CLK);
            #1;
            checks++;
            if (q4 !== 4'b0000) begin
                failures++;
                $display("FAIL mid_reset_hold[%0d]: got %b expected %b", i, q4, 4'b0000);
            end
        end
    endtask

    task automatic test_release_align();
        @(negedge CLK);
        d4 = 4'b1010;
        @(posedge CLK);
        // Nonblocking so the release lands in the same time step as the edge,
        // after the register has already sampled RST low.
        RST <= 1'b1;
        #1;
        checks++;
        if (q4 !== 4'b0000) begin
            failures++;
            $display("FAIL release_edge: got %b expected %b", q4, 4'b0000);
        end
        @(posedge CLK);
        #1;
        checks++;
        if (q4 !== 4'b1010) begin
            failures++;
            $display("FAIL release_next: got %b expected %b", q4, 4'b1010);
        end
    endtask

    task automatic test_width();
        logic [31:0] v32 [6];
        logic [0:0]  v1  [6];
        v32[0] = 32'hDEAD_BEEF;  v1[0] = 1'b1;
        v32[1] = 32'h0000_0001;  v1[1] = 1'b0;
        v32[2] = 32'h8000_0000;  v1[2] = 1'b1;
        v32[3] = 32'hFFFF_FFFF;  v1[3] = 1'b1;
        v32[4] = 32'hFFFF_FFFF;  v1[4] = 1'b1;
        v32[5] = 32'h0000_0000;  v1[5] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            d32 = v32[i];
            d1  = v1[i];
            @(posedge CLK);
            #1;
            checks++;
            if (q32 !== v32[i]) begin
                failures++;
                $display("FAIL width32[%0d]: got %h expected %h", i, q32, v32[i]);
            end
            checks++;
            if (q1 !== v1[i]) begin
                failures++;
                $display("FAIL width1[%0d]: got %b expected %b", i, q1, v1[i]);
            end
            // Toggle d between edges; q must not follow.
            #2;
            d32 = ~v32[i];
            d1  = ~v1[i];
            #1;
            checks++;
            if (q32 !== v32[i]) begin
                failures++;
                $display("FAIL hold32[%0d]: got %h expected %h", i, q32, v32[i]);
            end
            checks++;
            if (q1 !== v1[i]) begin
                failures++;
                $display("FAIL hold1[%0d]: got %b expected %b", i, q1, v1[i]);
            end
        end
    endtask

    task automatic test_rst_val();
        @(negedge CLK);
        d4 = 4'b1010;
        @(posedge CLK);
        #1;
        checks++;
        if (qrv !== 4'b1010) begin
            failures++;
            $display("FAIL rstval_capture: got %b expected %b", qrv, 4'b1010);
        end
        #2;
        RST = 1'b0;
        #1;
        checks++;
        if (qrv !== 4'b0101) begin
            failures++;
            $display("FAIL rstval_async: got %b expected %b", qrv, 4'b0101);
        end
        checks++;
        if (q4 !== 4'b0000) begin
            failures++;
            $display("FAIL rstval_q4: got %b expected %b", q4, 4'b0000);
        end
        @(negedge CLK);
        RST = 1'b1;
        d4  = 4'b0011;
        @(posedge CLK);
        #1;
        checks++;
        if (qrv !== 4'b0011) begin
            failures++;
            $display("FAIL rstval_after_release: got %b expected %b", qrv, 4'b0011);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_capture();
        test_mid_reset();
        test_release_align();
        test_width();
        test_rst_val();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
